// File: rtl/memory_unpack.sv
// memory_unpack: serial bit stream in, fixed-size packs out as bytes.
// Bits are assembled MSB-first into bytes, stored in a two-bank ping-pong
// RAM and each completed pack is streamed out with an end-of-pack marker.
module memory_unpack #(
    parameter int SIZE_BIT_PACK      = 1976,
    parameter int SIZE_OUTPUT_BIT    = 8,
    parameter int LENGTHE_OUTPUT_BIT = SIZE_BIT_PACK / SIZE_OUTPUT_BIT,
    parameter int SIZE_ADDR_OUTPUT   = $clog2(LENGTHE_OUTPUT_BIT)
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_valid,
    input  logic                       i_data,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_last,
    input  logic                       i_ready
);

    localparam int BIT_W = (SIZE_OUTPUT_BIT > 1) ? $clog2(SIZE_OUTPUT_BIT) : 1;
    localparam int DEPTH = 2 * LENGTHE_OUTPUT_BIT;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [BIT_W-1:0]            LAST_BIT   = BIT_W'(SIZE_OUTPUT_BIT - 1);
    localparam logic [SIZE_ADDR_OUTPUT-1:0] LAST_ADDR  = SIZE_ADDR_OUTPUT'(LENGTHE_OUTPUT_BIT - 1);
    localparam logic [IDX_W-1:0]            BANK1_BASE = IDX_W'(LENGTHE_OUTPUT_BIT);

    // The 8th bit of a byte comes straight from i_data, so only the first
    // SIZE_OUTPUT_BIT-1 bits need to be held.
    logic [SIZE_OUTPUT_BIT-2:0]  shift_reg;
    logic [BIT_W-1:0]            bit_cnt;
    logic [SIZE_ADDR_OUTPUT-1:0] waddr;
    logic                        wb;

    logic [1:0]                  full;
    logic [1:0]                  full_next;
    logic                        rb;

    // Fetch pointer runs ahead of rb so the next pack can be prefetched
    // while the previous pack's last bytes are still in the output pipeline.
    logic                        fb;
    logic [SIZE_ADDR_OUTPUT-1:0] faddr;

    logic                        rd_valid;
    logic                        rd_last;
    logic [SIZE_OUTPUT_BIT-1:0]  rd_data;

    logic                        accept;
    logic                        byte_done;
    logic                        pack_done;
    logic [SIZE_OUTPUT_BIT-1:0]  wr_byte;
    logic [IDX_W-1:0]            wr_idx;
    logic [IDX_W-1:0]            rd_idx;
    logic                        out_adv;
    logic                        rd_adv;
    logic                        fetch;
    logic                        fetch_last;
    logic                        drain_done;

    logic [SIZE_OUTPUT_BIT-1:0]  mem [DEPTH];

    assign o_ready = ~full[wb];

    // Handshake decode, RAM addressing and pipeline advance conditions
    always_comb begin
        accept     = i_valid & o_ready;
        wr_byte    = {shift_reg, i_data};
        byte_done  = accept & (bit_cnt == LAST_BIT);
        pack_done  = byte_done & (waddr == LAST_ADDR);
        out_adv    = ~o_valid | i_ready;
        rd_adv     = ~rd_valid | out_adv;
        fetch      = full[fb] & rd_adv;
        fetch_last = fetch & (faddr == LAST_ADDR);
        drain_done = o_valid & i_ready & o_last;
        wr_idx     = wb ? (BANK1_BASE + IDX_W'(waddr)) : IDX_W'(waddr);
        rd_idx     = fb ? (BANK1_BASE + IDX_W'(faddr)) : IDX_W'(faddr);
    end

    // Bank occupancy: a completing fill and a finishing drain may hit both banks on one edge
    always_comb begin
        full_next = full;
        if (pack_done) begin
            full_next[wb] = 1'b1;
        end
        if (drain_done) begin
            full_next[rb] = 1'b0;
        end
    end

    // Write side: bit assembly, byte address and write bank
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            waddr     <= '0;
            wb        <= 1'b0;
        end else if (accept) begin
            shift_reg <= wr_byte[SIZE_OUTPUT_BIT-2:0];
            if (byte_done) begin
                bit_cnt <= '0;
                if (pack_done) begin
                    waddr <= '0;
                    wb    <= ~wb;
                end else begin
                    waddr <= waddr + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Bank state: full flags and the bank currently being drained
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            full <= 2'b00;
            rb   <= 1'b0;
        end else begin
            full <= full_next;
            if (drain_done) begin
                rb <= ~rb;
            end
        end
    end

    // Fetch pointer: walks each full bank in order, then moves to the other bank
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fb    <= 1'b0;
            faddr <= '0;
        end else if (fetch) begin
            if (fetch_last) begin
                faddr <= '0;
                fb    <= ~fb;
            end else begin
                faddr <= faddr + 1'b1;
            end
        end
    end

    // Storage write port
    always_ff @(posedge i_clk) begin
        if (byte_done) begin
            mem[wr_idx] <= wr_byte;
        end
    end

    // Storage read port; the read register holds its byte while the pipeline is stalled
    always_ff @(posedge i_clk) begin
        if (fetch) begin
            rd_data <= mem[rd_idx];
        end
    end

    // Read-stage tags travelling alongside the RAM read register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (rd_adv) begin
            rd_valid <= fetch;
            rd_last  <= fetch_last;
        end
    end

    // Output register: loads from the read stage whenever downstream can take it
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (out_adv) begin
            o_valid <= rd_valid;
            o_last  <= rd_valid & rd_last;
            if (rd_valid) begin
                o_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_unpack.sv
// tb_memory_unpack: randomized bench for memory_unpack with a pack-level
// reference model (queue of expected bytes in pack completion order).
module tb_memory_unpack;

    localparam int PACK_BITS  = 1976;
    localparam int PACK_BYTES = 247;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_data = 1'b0;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       i_ready = 1'b0;

    int vectorCount = 0;
    int missCount   = 0;

    bit         txbits[$];
    logic [7:0] expq[$];
    logic [7:0] pk [PACK_BYTES];

    int  cyc = 0;
    int  bitsAccepted = 0;
    int  outIdx = 0;
    int  readyLowCnt = 0;
    int  holdViol = 0;
    int  lastBitEdge = 0;
    int  lastDrainEdge = 0;
    int  readyMode = 1;
    bit  txPause = 0;
    bit  validRandom = 0;
    bit  latencyArmed = 0;
    bit  prevHold = 0;
    bit  prevValid = 0;
    logic [7:0] prevData = '0;
    logic       prevLast = 1'b0;

    memory_unpack dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_last    (o_last),
        .i_ready   (i_ready)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: inputs change 1 ns after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (!txPause && txbits.size() > 0 && (!validRandom || $urandom_range(0, 3) != 0)) begin
            i_valid = 1'b1;
            i_data  = txbits[0];
        end else begin
            i_valid = 1'b0;
            i_data  = 1'b0;
        end
        case (readyMode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'b0;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // kind 0: byte k = k, kind 1: byte k = 0xFF ^ k, otherwise random
    task automatic queuePack(input int kind);
        for (int k = 0; k < PACK_BYTES; k++) begin
            if (kind == 0)      pk[k] = 8'(k);
            else if (kind == 1) pk[k] = 8'hFF ^ 8'(k);
            else                pk[k] = 8'($urandom);
            expq.push_back(pk[k]);
            for (int b = 7; b >= 0; b--) begin
                txbits.push_back(pk[k][b]);
            end
        end
    endtask

    task automatic doReset();
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = 1'b0;
        i_ready   = 1'b0;
        readyMode = 1;
        txPause   = 0;
        validRandom = 0;
        #1;
        checkOutput("rst_o_valid", 32'(o_valid), 0);
        checkOutput("rst_o_ready", 32'(o_ready), 1);
        checkOutput("rst_o_data",  32'(o_data),  0);
        checkOutput("rst_o_last",  32'(o_last),  0);
        txbits.delete();
        expq.delete();
        bitsAccepted = 0;
        outIdx       = 0;
        readyLowCnt  = 0;
        holdViol     = 0;
        prevHold     = 0;
        prevValid    = 0;
        latencyArmed = 0;
        repeat (2) @(posedge clk);
        #1 i_reset_n = 1'b1;
    endtask

    task automatic runUntilAccepted(input int target, input int budget);
        int n = 0;
        while (bitsAccepted < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("bits_reached", 32'(bitsAccepted), 32'(target));
    endtask

    task automatic runUntilOut(input int target, input int budget);
        int n = 0;
        while (outIdx < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("bytes_reached", 32'(outIdx), 32'(target));
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((txbits.size() != 0 || expq.size() != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_done", 32'(txbits.size() + expq.size()), 0);
        repeat (8) applyStimulus();
    endtask

    // Monitor at the falling edge: what is seen here is what the next rising edge acts on
    initial forever begin
        @(negedge clk);
        if (i_reset_n) begin
            if (i_valid && o_ready) begin
                if (txbits.size() > 0) void'(txbits.pop_front());
                bitsAccepted++;
                if (bitsAccepted % PACK_BITS == 0) lastBitEdge = cyc + 1;
            end
            if (!o_ready) readyLowCnt++;
            if (prevHold && (!o_valid || o_data !== prevData || o_last !== prevLast)) holdViol++;
            prevHold = o_valid && !i_ready;
            prevData = o_data;
            prevLast = o_last;
            if (latencyArmed && o_valid && !prevValid) begin
                checkOutput("fill_latency", 32'(cyc - lastBitEdge), 2);
                latencyArmed = 0;
            end
            prevValid = o_valid;
            if (o_valid && i_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("extra_byte", 32'(o_data), 32'h100);
                end else begin
                    checkOutput("o_data", 32'(o_data), 32'(expq.pop_front()));
                    checkOutput("o_last", 32'(o_last), (outIdx % PACK_BYTES == PACK_BYTES - 1) ? 1 : 0);
                    if (o_last) lastDrainEdge = cyc + 1;
                    outIdx++;
                end
            end
        end
    end

    initial begin
        #3;

        // Single pack, counting pattern, downstream always ready
        doReset();
        readyMode = 0;
        latencyArmed = 1;
        queuePack(0);
        waitIdle(2600);
        checkOutput("single_bytes", 32'(outIdx), PACK_BYTES);
        checkOutput("single_ready_low", 32'(readyLowCnt), 0);
        checkOutput("single_latency_seen", 32'(latencyArmed), 0);

        // Both banks full under back-pressure, third pack must stall
        doReset();
        readyMode = 1;
        queuePack(0);
        queuePack(1);
        queuePack(2);
        runUntilAccepted(2 * PACK_BITS, 4500);
        checkOutput("both_full_ready", 32'(o_ready), 0);
        repeat (20) applyStimulus();
        checkOutput("third_stalled", 32'(bitsAccepted), 2 * PACK_BITS);
        readyMode = 0;
        runUntilOut(PACK_BYTES - 1, 600);
        checkOutput("ready_before_last", 32'(o_ready), 0);
        runUntilOut(PACK_BYTES, 50);
        checkOutput("ready_after_last", 32'(o_ready), 1);
        waitIdle(5000);
        checkOutput("both_full_bytes", 32'(outIdx), 3 * PACK_BYTES);
        checkOutput("both_full_hold", 32'(holdViol), 0);

        // Streaming four packs with continuous valid and ready
        doReset();
        readyMode = 0;
        for (int p = 0; p < 4; p++) queuePack(2);
        waitIdle(8600);
        checkOutput("stream_ready_low", 32'(readyLowCnt), 0);
        checkOutput("stream_bytes", 32'(outIdx), 4 * PACK_BYTES);

        // Random ready and random input gaps over three packs
        doReset();
        readyMode = 2;
        validRandom = 1;
        for (int p = 0; p < 3; p++) queuePack(2);
        waitIdle(12000);
        checkOutput("random_bytes", 32'(outIdx), 3 * PACK_BYTES);
        checkOutput("random_hold", 32'(holdViol), 0);
        validRandom = 0;

        // Reset in the middle of a fill and of a drain
        doReset();
        readyMode = 1;
        queuePack(2);
        queuePack(2);
        runUntilAccepted(PACK_BITS + 1000, 3500);
        txPause = 1;
        i_valid = 1'b0;
        readyMode = 0;
        repeat (20) applyStimulus();
        checkOutput("mid_drain", 32'(outIdx > 0 && outIdx < PACK_BYTES), 1);
        doReset();
        readyMode = 0;
        queuePack(2);
        waitIdle(2600);
        checkOutput("post_reset_bytes", 32'(outIdx), PACK_BYTES);

        // Final bit of bank 1 lands on the o_last handshake of bank 0
        doReset();
        readyMode = 1;
        queuePack(2);
        queuePack(2);
        runUntilAccepted(2 * PACK_BITS - 1, 4500);
        txPause = 1;
        i_valid = 1'b0;
        readyMode = 0;
        begin
            int n = 0;
            while (!(o_valid && o_last && i_ready) && n < 600) begin
                applyStimulus();
                n++;
            end
        end
        checkOutput("last_presented", 32'(o_valid && o_last), 1);
        txPause = 0;
        i_valid = 1'b1;
        i_data  = txbits[0];
        latencyArmed = 1;
        applyStimulus();
        checkOutput("coincident_edge", 32'(lastBitEdge), 32'(lastDrainEdge));
        waitIdle(600);
        checkOutput("coincident_latency_seen", 32'(latencyArmed), 0);
        checkOutput("coincident_ready_low", 32'(readyLowCnt), 0);
        checkOutput("coincident_bytes", 32'(outIdx), 2 * PACK_BYTES);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
